// File: rtl/i2s_wavetable_synth.sv
// Polyphonic wavetable synthesiser: per-frame sequential voice mix with saturation,
// shifted out to an I2S codec (same sample on left and right).
module i2s_wavetable_synth #(
  parameter int NUM_VOICES  = 12,
  parameter int TABLE_DEPTH = 8,
  parameter int SAMPLE_W    = 24,
  parameter int PHASE_W     = 16,
  parameter int KEY_SLOTS   = 4,
  localparam int AW = (TABLE_DEPTH > 1) ? $clog2(TABLE_DEPTH) : 1,
  localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   SCLK,
  input  logic                   LRCLK,
  output logic                   Dout,
  input  logic [8*KEY_SLOTS-1:0] keycode,
  input  logic [AW-1:0]          tbl_address,
  input  logic                   tbl_write,
  input  logic [31:0]            tbl_writedata,
  output logic [31:0]            tbl_readdata,
  input  logic [VW-1:0]          cfg_voice,
  input  logic                   cfg_write,
  input  logic [7:0]             cfg_key,
  input  logic [PHASE_W-1:0]     cfg_step,
  output logic                   clip
);

  localparam int ACC_W = SAMPLE_W + VW + 1;
  localparam int CW    = $clog2(SAMPLE_W + 1);
  localparam logic [VW-1:0] LAST_V = VW'(NUM_VOICES - 1);
  localparam logic signed [ACC_W-1:0] ACC_MAX =
    {{(ACC_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN =
    {{(ACC_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};
  localparam logic signed [SAMPLE_W-1:0] SAT_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [SAMPLE_W-1:0] SAT_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_SAT} state_t;

  state_t r_state, w_state_next;

  logic [1:0] r_sclk_sync, r_lr_sync;
  logic       r_sclk_d, r_lr_d;
  logic       w_sclk_fall, w_lr_fall, w_lr_rise, w_tick;

  logic signed [SAMPLE_W-1:0] r_table [TABLE_DEPTH];
  logic [7:0]                 r_key   [NUM_VOICES];
  logic [PHASE_W-1:0]         r_step  [NUM_VOICES];
  logic [PHASE_W-1:0]         r_phase [NUM_VOICES];
  logic [KEY_SLOTS-1:0]       w_hit   [NUM_VOICES];
  logic [NUM_VOICES-1:0]      w_active;

  logic signed [ACC_W-1:0]    r_acc;
  logic [VW-1:0]              r_vidx;
  logic signed [SAMPLE_W-1:0] r_held, r_out;
  logic [PHASE_W-1:0]         w_phase_sel;
  logic signed [SAMPLE_W-1:0] w_entry, w_sat_val;
  logic signed [ACC_W-1:0]    w_term;
  logic                       w_clamp_hi, w_clamp_lo, w_clip;

  logic [SAMPLE_W-1:0]        r_shift, w_load_val;
  logic [CW-1:0]              r_bitcnt;
  logic                       r_dout;
  logic                       w_unused_bits;

  // Two-flop synchronisers plus one delay flop for edge detection.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_sclk_sync <= '0;
      r_lr_sync   <= '0;
      r_sclk_d    <= 1'b0;
      r_lr_d      <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[0], SCLK};
      r_lr_sync   <= {r_lr_sync[0], LRCLK};
      r_sclk_d    <= r_sclk_sync[1];
      r_lr_d      <= r_lr_sync[1];
    end
  end

  assign w_sclk_fall = r_sclk_d & ~r_sclk_sync[1];
  assign w_lr_fall   = r_lr_d & ~r_lr_sync[1];
  assign w_lr_rise   = ~r_lr_d & r_lr_sync[1];
  assign w_tick      = (r_state == S_IDLE) && w_lr_fall;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < TABLE_DEPTH; i++) r_table[i] <= '0;
    end else if (tbl_write) begin
      r_table[tbl_address] <= tbl_writedata[31 -: SAMPLE_W];
    end
  end

  assign tbl_readdata  = {{(32-SAMPLE_W){1'b0}}, r_table[tbl_address]};
  assign w_unused_bits = ^tbl_writedata[31-SAMPLE_W:0];

  genvar gi, si;
  generate
    for (gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
      for (si = 0; si < KEY_SLOTS; si++) begin : g_slot
        assign w_hit[gi][si] = (keycode[8*si +: 8] == r_key[gi]);
      end
      assign w_active[gi] = (r_key[gi] != 8'd0) && (|w_hit[gi]);
    end
  endgenerate

  // An idle voice parks its phase at 0 so the next key press restarts the wave.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        r_key[v]   <= '0;
        r_step[v]  <= '0;
        r_phase[v] <= '0;
      end
    end else begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (!w_active[v])
          r_phase[v] <= '0;
        else if (w_tick)
          r_phase[v] <= r_phase[v] + r_step[v];
        if (cfg_write && (cfg_voice == VW'(v))) begin
          r_key[v]  <= cfg_key;
          r_step[v] <= cfg_step;
        end
      end
    end
  end

  assign w_phase_sel = r_phase[r_vidx];
  assign w_entry     = r_table[w_phase_sel[PHASE_W-1 -: AW]];
  assign w_term      = w_active[r_vidx] ?
                       {{(ACC_W-SAMPLE_W){w_entry[SAMPLE_W-1]}}, w_entry} : '0;
  assign w_clamp_hi  = (r_acc > ACC_MAX);
  assign w_clamp_lo  = (r_acc < ACC_MIN);

  always_ff @(posedge CLK) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_clip       = 1'b0;
    w_sat_val    = r_acc[SAMPLE_W-1:0];
    if (w_clamp_hi)      w_sat_val = SAT_MAX;
    else if (w_clamp_lo) w_sat_val = SAT_MIN;
    case (r_state)
      S_IDLE:  if (w_lr_fall) w_state_next = S_ACCUM;
      S_ACCUM: if (r_vidx == LAST_V) w_state_next = S_SAT;
      S_SAT: begin
        w_state_next = S_IDLE;
        w_clip       = w_clamp_hi | w_clamp_lo;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_acc  <= '0;
      r_vidx <= '0;
      r_held <= '0;
      r_out  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_lr_fall) begin
          r_out  <= r_held;
          r_acc  <= '0;
          r_vidx <= '0;
        end
        S_ACCUM: begin
          r_acc  <= r_acc + w_term;
          r_vidx <= r_vidx + 1'b1;
        end
        S_SAT:   r_held <= w_sat_val;
        default: ;
      endcase
    end
  end

  assign clip = w_clip;

  // Load the value out_sample takes this cycle so both channels carry the same frame.
  assign w_load_val = w_tick ? r_held : r_out;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_shift  <= '0;
      r_bitcnt <= '0;
      r_dout   <= 1'b0;
    end else begin
      if (w_sclk_fall)
        r_dout <= (r_bitcnt != '0) ? r_shift[SAMPLE_W-1] : 1'b0;
      if (w_lr_fall || w_lr_rise) begin
        r_shift  <= w_load_val;
        r_bitcnt <= CW'(SAMPLE_W);
      end else if (w_sclk_fall && (r_bitcnt != '0)) begin
        r_shift  <= r_shift << 1;
        r_bitcnt <= r_bitcnt - 1'b1;
      end
    end
  end

  assign Dout = r_dout;

endmodule

// File: tb/tb_i2s_wavetable_synth.sv
// Directed bench: a codec model drives SCLK/LRCLK (32 bits per channel) and
// captures each channel slot from Dout; checks are immediate assertions.
module tb_i2s_wavetable_synth;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        SCLK = 1'b1;
  logic        LRCLK = 1'b0;
  logic        Dout;
  logic [31:0] keycode = '0;
  logic [2:0]  tbl_address = '0;
  logic        tbl_write = 1'b0;
  logic [31:0] tbl_writedata = '0;
  logic [31:0] tbl_readdata;
  logic [3:0]  cfg_voice = '0;
  logic        cfg_write = 1'b0;
  logic [7:0]  cfg_key = '0;
  logic [15:0] cfg_step = '0;
  logic        clip;

  int tests = 0;
  int fails = 0;
  int bitpos = 63;
  int left_cnt = 0;
  int frame_cnt = 0;
  int clip_cnt = 0;
  logic [31:0] slot = '0, left_hold = '0, pub_left = '0, pub_right = '0;

  i2s_wavetable_synth dut (
    .CLK(CLK), .RESET(RESET), .SCLK(SCLK), .LRCLK(LRCLK), .Dout(Dout),
    .keycode(keycode), .tbl_address(tbl_address), .tbl_write(tbl_write),
    .tbl_writedata(tbl_writedata), .tbl_readdata(tbl_readdata),
    .cfg_voice(cfg_voice), .cfg_write(cfg_write), .cfg_key(cfg_key),
    .cfg_step(cfg_step), .clip(clip)
  );

  always #5 CLK = ~CLK;
  initial forever #40 SCLK = ~SCLK;

  // Codec: LRCLK changes on SCLK fall; data sampled on SCLK rise.
  always @(negedge SCLK) begin
    bitpos = (bitpos + 1) % 64;
    LRCLK  = (bitpos >= 32);
  end

  always @(posedge SCLK) begin
    slot[31 - (bitpos % 32)] = Dout;
    if (bitpos == 31) begin
      left_hold = slot;
      left_cnt++;
    end
    if (bitpos == 63) begin
      pub_left  = left_hold;
      pub_right = slot;
      frame_cnt++;
    end
  end

  always @(negedge CLK) if (clip === 1'b1) clip_cnt++;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] slot_of(input logic [23:0] s);
    return {1'b0, s, 7'b0};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic get_frame();
    int start;
    start = frame_cnt;
    for (int i = 0; i < 2000 && frame_cnt == start; i++) @(posedge CLK);
    check("frame_timeout", 32'(frame_cnt - start), 32'd1);
  endtask

  task automatic wait_left();
    int start;
    start = left_cnt;
    for (int i = 0; i < 2000 && left_cnt == start; i++) @(posedge CLK);
    check("left_timeout", 32'(left_cnt - start), 32'd1);
  endtask

  task automatic check_frame(input string tag, input logic [23:0] exp, input int exp_clip);
    int c0;
    c0 = clip_cnt;
    get_frame();
    $display("[TB] frame %s L=%h R=%h exp=%h", tag, pub_left, pub_right, slot_of(exp));
    check({tag, "_L"}, pub_left, slot_of(exp));
    check({tag, "_R"}, pub_right, slot_of(exp));
    if (exp_clip >= 0) check({tag, "_clip"}, 32'(clip_cnt - c0), 32'(exp_clip));
  endtask

  task automatic tbl_wr(input int addr, input logic [23:0] val);
    @(negedge CLK);
    tbl_address   = 3'(addr);
    tbl_writedata = {val, 8'h00};
    tbl_write     = 1'b1;
    @(negedge CLK);
    tbl_write     = 1'b0;
  endtask

  task automatic fill(input logic [23:0] val);
    for (int i = 0; i < 8; i++) tbl_wr(i, val);
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < 8; i++) tbl_wr(i, 24'(i));
  endtask

  task automatic cfg_wr(input int v, input logic [7:0] key, input logic [15:0] step);
    @(negedge CLK);
    cfg_voice = 4'(v);
    cfg_key   = key;
    cfg_step  = step;
    cfg_write = 1'b1;
    @(negedge CLK);
    cfg_write = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge CLK);
    @(negedge CLK) RESET = 1'b0;
    for (int a = 0; a < 8; a++) begin
      tbl_address = 3'(a);
      #1;
      check($sformatf("rst_rd%0d", a), tbl_readdata, 32'h0);
    end
    check("rst_dout", {31'b0, Dout}, 32'h0);
    check_frame("rst0", 24'h0, 0);
    check_frame("rst1", 24'h0, 0);

    // Table access
    tbl_wr(3, 24'hABCDEF);
    check("tbl_rd3", tbl_readdata, 32'h00ABCDEF);
    tbl_address = 3'd2;
    #1;
    check("tbl_rd2", tbl_readdata, 32'h0);

    // Single voice
    wait_left();
    fill(24'h100000);
    cfg_wr(0, 8'h04, 16'h0100);
    keycode = 32'h0000_0004;
    check_frame("sv0", 24'h0, -1);
    check_frame("sv1", 24'h0, 0);
    check_frame("sv2", 24'h100000, 0);
    check_frame("sv3", 24'h100000, 0);
    wait_left();
    keycode = 32'h0;
    check_frame("rel0", 24'h100000, -1);
    check_frame("rel1", 24'h100000, 0);
    check_frame("rel2", 24'h0, 0);

    // Phase wrap on voice 3, key in slot 2
    wait_left();
    cfg_wr(0, 8'h00, 16'h0);
    fill_ramp();
    cfg_wr(3, 8'h10, 16'h2000);
    keycode = 32'h0010_0000;
    check_frame("wrapA", 24'h0, -1);
    check_frame("wrapB", 24'h0, -1);
    for (int k = 2; k <= 10; k++)
      check_frame($sformatf("wrap%0d", k), 24'((k - 1) % 8), 0);
    wait_left();
    keycode = 32'h0;
    check_frame("wrel0", 24'd2, -1);
    wait_left();
    keycode = 32'h0010_0000;
    check_frame("wrel1", 24'd3, -1);
    check_frame("wrel2", 24'd0, -1);
    check_frame("wpress1", 24'd1, -1);
    check_frame("wpress2", 24'd2, -1);

    // Saturation
    wait_left();
    fill(24'h7FFFFF);
    for (int v = 0; v < 12; v++) cfg_wr(v, 8'h04, 16'h0);
    keycode = 32'h0000_0004;
    get_frame();
    get_frame();
    check_frame("satp0", 24'h7FFFFF, 1);
    check_frame("satp1", 24'h7FFFFF, 1);
    wait_left();
    fill(24'h800000);
    get_frame();
    get_frame();
    check_frame("satn0", 24'h800000, 1);
    check_frame("satn1", 24'h800000, 1);
    wait_left();
    fill(24'h300000);
    for (int v = 2; v < 12; v++) cfg_wr(v, 8'h00, 16'h0);
    get_frame();
    get_frame();
    check_frame("sum2", 24'h600000, 0);

    // Reset in the middle of ACCUM
    get_frame();
    @(negedge SCLK);
    repeat (6) @(posedge CLK);
    @(negedge CLK) RESET = 1'b1;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    tbl_address = 3'd0;
    #1;
    check("mid_tbl", tbl_readdata, 32'h0);
    check_frame("mid0", 24'h0, -1);
    wait_left();
    fill(24'h100000);
    check_frame("mid1", 24'h0, -1);
    check_frame("mid2", 24'h0, -1);
    check_frame("mid3", 24'h0, 0);

    // Step change mid-frame on the last voice, key in slot 3
    wait_left();
    fill_ramp();
    cfg_wr(11, 8'h21, 16'h2000);
    keycode = 32'h2100_0000;
    check_frame("st0", 24'd0, -1);
    check_frame("st1", 24'd0, -1);
    check_frame("st2", 24'd1, -1);
    check_frame("st3", 24'd2, -1);
    wait_left();
    cfg_wr(11, 8'h21, 16'h4000);
    check_frame("st4", 24'd3, -1);
    check_frame("st5", 24'd4, -1);
    check_frame("st6", 24'd6, -1);
    check_frame("st7", 24'd0, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/i2s_wavetable_synth.md
Name: i2s_wavetable_synth

Overview:
- Polyphonic wavetable synthesiser with an I2S transmitter, all in the system CLK domain.
- Holds one shared signed wavetable and NUM_VOICES voices; each voice has a programmable key code and a fractional phase step.
- Once per audio frame it sums the active voices sequentially, saturates the result, and shifts it out MSB-first to the codec on both channels.
- Sits between the Avalon/CPU register bus (table and voice config), the USB keyboard keycode register, and the codec pins.

Parameters:
NUM_VOICES, 12, number of voices (1..32)
TABLE_DEPTH, 8, wavetable entries, power of 2 (2..1024)
SAMPLE_W, 24, signed sample/output width (8..24)
PHASE_W, 16, phase accumulator width, > log2(TABLE_DEPTH)
KEY_SLOTS, 4, simultaneous keycode bytes

Ports:
CLK  in  1  system clock
RESET  in  1  synchronous, active-high reset
SCLK  in  1  codec bit clock, asynchronous, slower than CLK/4
LRCLK  in  1  codec word clock; 0 = left, 1 = right
Dout  out  1  I2S serial data
keycode  in  8*KEY_SLOTS  pressed-key codes, byte per slot, 0 = none
tbl_address  in  clog2(TABLE_DEPTH)  wavetable index
tbl_write  in  1  wavetable write strobe
tbl_writedata  in  32  entry = tbl_writedata[31 -: SAMPLE_W]
tbl_readdata  out  32  zero-extended stored entry at tbl_address (combinational)
cfg_voice  in  clog2(NUM_VOICES)  voice select
cfg_write  in  1  voice config write strobe
cfg_key  in  8  keycode that gates the voice; 0 = disabled
cfg_step  in  PHASE_W  phase increment per frame
clip  out  1  one-cycle pulse when a mix saturates

Behaviour:
- Reset (sync, CLK): all table entries, voice keys/steps, phases, held/out samples and shift register are 0. FSM goes to IDLE. Dout=0, clip=0. Reset mid-ACCUM aborts the mix; no partial result is kept.
- Sync and edge detect: SCLK and LRCLK each pass through 2-FF synchronisers. Single-cycle sclk_fall, lr_fall and lr_rise strobes come from the synchronised values.
- Writes are registered and visible next cycle:
  - tbl_write has priority over nothing; bus reads are combinational from the array.
  - A table or voice write in the same cycle as ACCUM reads the old value for that cycle.
- Voice active(v): cfg_key[v] != 0 and it equals any keycode byte. An inactive voice holds phase=0 and contributes 0.
- FSM, started on lr_fall (frame tick):
  - IDLE: on lr_fall, copy held_sample into out_sample. Every active voice adds cfg_step to its phase, mod 2^PHASE_W. Clear the accumulator and voice index. Go to ACCUM.
  - ACCUM: one voice per cycle, v = 0..NUM_VOICES-1. acc += active ? sext(table[phase[v][PHASE_W-1 -: clog2(TABLE_DEPTH)]]) : 0. acc width is SAMPLE_W+clog2(NUM_VOICES)+1. After the last voice, go to SAT.
  - SAT: clamp acc to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1] and write it to held_sample. clip=1 for this cycle if clamped. Go to IDLE.
  - lr_fall arriving while not in IDLE: ignored (the frame is skipped). This cannot happen at legal clock ratios.
- Mix latency: the sample computed after frame tick k is output in frame k+1, on both left and right.
- Serializer (SAMPLE_W-bit shift register, changes only on sclk_fall):
  - An lr_fall or lr_rise loads out_sample and arms the bit counter at SAMPLE_W.
  - The next sclk_fall drives the MSB (standard one-bit I2S delay). Each following sclk_fall shifts left by one.
  - After SAMPLE_W bits, Dout=0 until the next LRCLK edge.
  - A new LRCLK edge reloads immediately, truncating any bits not yet sent.
- Width rules: all table and mix arithmetic is signed two's complement. Phase wrap is natural overflow. tbl_readdata = {(32-SAMPLE_W) zeros, entry}.

Test Plan:
- Reset: assert RESET 2 cycles, then run frames -> Dout stays 0; tbl_readdata=0 for every address; clip never pulses.
- Table access: write 0xABCDEF00 to address 3 -> next cycle tbl_readdata=0x00ABCDEF; address 2 still reads 0.
- Single voice: all entries 0x100000, voice0 key 0x04 step 0x0100, keycode=0x00000004 -> from the second frame on, left and right each serialize 0x100000 MSB-first starting one SCLK after the LRCLK edge, then zeros; keycode=0 -> output 0 from the frame after next.
- Phase wrap: table = ramp 0..7, voice3 step 0x2000, key held -> successive frames output 1,2,...,7,0,1 (index advances exactly one per frame and wraps at 8); release key -> next press restarts at index 1.
- Saturation: all 12 voices keyed, all entries 0x7FFFFF -> output 0x7FFFFF with a clip pulse each frame; entries 0x800000 -> output 0x800000 with clip; 2 voices at 0x300000 -> 0x600000 with no clip.
- Mid-operation: RESET asserted in the middle of ACCUM -> next output frame 0, config cleared. Voice step write issued mid-frame -> new step applies from the following frame tick only.
